// File: rtl/pulse_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_frame_decoder
//  Description : Decodes low-pulse frames on an idle-high serial line. A frame
//                is a low run of 2..MAX_LOW samples followed by at least two
//                high samples. Reports legal frames and violations (runt, long,
//                guard) as registered one-cycle pulses, keeps the last legal
//                run length, and counts frames/errors with saturation.
//                All state advances on the falling edge of clk.
//  Revision    : 1.0  initial release
// ============================================================================
module pulse_frame_decoder #(
    parameter int MAX_LOW = 8,   // longest legal low run, 2..15
    parameter int CNT_W   = 8    // width of the frame counters
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active low
    input  logic             din,
    input  logic             clr,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [1:0]       err_code,
    output logic [3:0]       last_len,
    output logic [CNT_W-1:0] ok_count,
    output logic [CNT_W-1:0] err_count,
    output logic             busy
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOW   = 2'd1;
    localparam logic [1:0] c_GUARD = 2'd2;
    localparam logic [1:0] c_LONG  = 2'd3;

    localparam logic [1:0] c_ERR_RUNT  = 2'd1;
    localparam logic [1:0] c_ERR_LONG  = 2'd2;
    localparam logic [1:0] c_ERR_GUARD = 2'd3;

    localparam logic [3:0]       c_MAX_LOW = 4'(MAX_LOW);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       state_q,     state_d;
    logic [3:0]       run_q,       run_d;
    logic             frame_ok_q,  frame_ok_d;
    logic             frame_err_q, frame_err_d;
    logic [1:0]       err_code_q,  err_code_d;
    logic [3:0]       last_len_q,  last_len_d;
    logic [CNT_W-1:0] ok_count_q,  ok_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    // Frame FSM: next state, run length and the registered result pulses
    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        last_len_d  = last_len_q;

        case (state_q)
            c_IDLE: begin
                if (!din) begin
                    state_d = c_LOW;
                    run_d   = 4'd1;
                end
            end
            c_LOW: begin
                if (!din) begin
                    if (run_q == c_MAX_LOW) begin
                        state_d     = c_LONG;
                        frame_err_d = 1'b1;
                        err_code_d  = c_ERR_LONG;
                    end else begin
                        run_d = run_q + 4'd1;
                    end
                end else if (run_q >= 4'd2) begin
                    // run is held so the guard can report it as last_len
                    state_d = c_GUARD;
                end else begin
                    state_d     = c_IDLE;
                    run_d       = 4'd0;
                    frame_err_d = 1'b1;
                    err_code_d  = c_ERR_RUNT;
                end
            end
            c_GUARD: begin
                if (din) begin
                    state_d    = c_IDLE;
                    run_d      = 4'd0;
                    frame_ok_d = 1'b1;
                    last_len_d = run_q;
                end else begin
                    // the offending low sample is the first of a new frame
                    state_d     = c_LOW;
                    run_d       = 4'd1;
                    frame_err_d = 1'b1;
                    err_code_d  = c_ERR_GUARD;
                end
            end
            c_LONG: begin
                if (din) begin
                    state_d = c_IDLE;
                    run_d   = 4'd0;
                end
            end
            default: begin
                state_d = c_IDLE;
                run_d   = 4'd0;
            end
        endcase
    end

    // Saturating counters stepped by the pulses being launched; clr has priority
    always_comb begin
        ok_count_d  = ok_count_q;
        err_count_d = err_count_q;
        if (clr) begin
            ok_count_d  = '0;
            err_count_d = '0;
        end else begin
            if (frame_ok_d && (ok_count_q != c_CNT_MAX)) begin
                ok_count_d = ok_count_q + 1'b1;
            end
            if (frame_err_d && (err_count_q != c_CNT_MAX)) begin
                err_count_d = err_count_q + 1'b1;
            end
        end
    end

    // State and output registers, falling-edge clocked, async active-low reset
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= c_IDLE;
            run_q       <= 4'd0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'd0;
            last_len_q  <= 4'd0;
            ok_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            last_len_q  <= last_len_d;
            ok_count_q  <= ok_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign last_len  = last_len_q;
    assign ok_count  = ok_count_q;
    assign err_count = err_count_q;
    assign busy      = (state_q != c_IDLE);

endmodule
`default_nettype wire
